// File: rtl/tempsens_pkg.sv
// Shared FSM state type and timing helpers for the multi-channel SAR temperature
// sensor controller.
package tempsens_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_TRANSITION,
    ST_MEASURE,
    ST_EVALUATE,
    ST_ACCUM,
    ST_DONE
  } state_e;

  localparam int VMIN = 0;

  function automatic int vmax(input int n_vdac);
    return (1 << n_vdac) - 1;
  endfunction

  function automatic int trial_cycles(input int meas_cyc);
    return meas_cyc + 3;
  endfunction

  function automatic int sample_cycles(input int n_vdac, input int meas_cyc);
    return n_vdac * trial_cycles(meas_cyc) + 1;
  endfunction

  // Half an LSB of the averaged result, so the final shift rounds to nearest.
  function automatic int round_term(input int avg_log2);
    return (avg_log2 == 0) ? 0 : (1 << (avg_log2 - 1));
  endfunction

endpackage

// File: rtl/tempsens_sync.sv
// Two-flop synchronizer for the asynchronous delay-cell outputs, one bit per channel.
module tempsens_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so both stages update from pre-edge values.
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/tempsens_sar_ctrl.sv
// Scans enabled delay-cell channels over one shared DAC, resolving each with a SAR
// search, averaging 2^AVG_LOG2 samples and emitting one rounded result per channel.
module tempsens_sar_ctrl
  import tempsens_pkg::*;
#(
  parameter  int N_VDAC   = 7,
  parameter  int N_CH     = 4,
  parameter  int AVG_LOG2 = 2,
  parameter  int MEAS_CYC = 4,
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic [N_CH-1:0]   i_ch_mask,
  input  logic [N_CH-1:0]   i_tempdelay,
  output logic [N_VDAC-1:0] o_dac_data,
  output logic [N_CH-1:0]   o_dac_en,
  output logic [N_CH-1:0]   o_precharge_n,
  output logic              o_busy,
  output logic              o_res_valid,
  output logic [CHW-1:0]    o_res_ch,
  output logic [N_VDAC-1:0] o_res_data,
  output logic              o_res_oor
);

  localparam int VMAX_C = vmax(N_VDAC);
  localparam int BW     = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
  localparam int CW     = (MEAS_CYC > 1) ? $clog2(MEAS_CYC) : 1;
  localparam int SW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW     = N_VDAC + AVG_LOG2;
  localparam int N_SAMP = 1 << AVG_LOG2;
  localparam int RND    = round_term(AVG_LOG2);
  localparam logic [BW-1:0] BIT_TOP = BW'(N_VDAC - 1);

  state_e              state_q, state_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [N_VDAC-1:0]   code_q, code_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       samp_q, samp_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic                oor_q, oor_d;
  logic [CHW-1:0]      res_ch_q, res_ch_d;
  logic [N_VDAC-1:0]   res_data_q, res_data_d;
  logic                res_oor_q, res_oor_d;

  logic [N_CH-1:0]     sync_td;
  logic [N_VDAC-1:0]   trial;
  logic [AW-1:0]       acc_sum;
  logic [AW:0]         rnd_sum;
  logic                sample_oor;

  tempsens_sync #(.W(N_CH)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (i_tempdelay),
    .o_sync  (sync_td)
  );

  // Lowest set channel at or above lo; any_from tells whether one exists.
  function automatic logic [CHW-1:0] lowest_from(input logic [N_CH-1:0] m, input int lo);
    logic [CHW-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i] && i >= lo) r = CHW'(i);
    return r;
  endfunction

  function automatic logic any_from(input logic [N_CH-1:0] m, input int lo);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (m[i] && i >= lo) r = 1'b1;
    return r;
  endfunction

  assign trial      = code_q | (N_VDAC'(1) << bit_q);
  assign acc_sum    = acc_q + AW'(code_q);
  assign rnd_sum    = {1'b0, acc_sum} + (AW+1)'(RND);
  assign sample_oor = (code_q == N_VDAC'(VMIN)) || (code_q == N_VDAC'(VMAX_C));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      ch_q       <= '0;
      code_q     <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      samp_q     <= '0;
      acc_q      <= '0;
      oor_q      <= 1'b0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      res_oor_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      code_q     <= code_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      acc_q      <= acc_d;
      oor_q      <= oor_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      res_oor_q  <= res_oor_d;
    end
  end

  always_comb begin
    // NOTE: every _d starts at its hold value so no path leaves one unassigned (no latch).
    state_d    = state_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    code_d     = code_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    samp_d     = samp_q;
    acc_d      = acc_q;
    oor_d      = oor_q;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    res_oor_d  = res_oor_q;
    case (state_q)
      ST_IDLE: if (i_start && |i_ch_mask) begin
        mask_d  = i_ch_mask;
        ch_d    = lowest_from(i_ch_mask, 0);
        code_d  = '0;
        bit_d   = BIT_TOP;
        samp_d  = '0;
        acc_d   = '0;
        oor_d   = 1'b0;
        state_d = ST_PRECHARGE;
      end
      ST_PRECHARGE:  state_d = ST_TRANSITION;
      ST_TRANSITION: begin
        cnt_d   = '0;
        state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (cnt_q == CW'(MEAS_CYC - 1)) state_d = ST_EVALUATE;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      ST_EVALUATE: begin
        if (sync_td[ch_q]) code_d = trial;
        if (bit_q == '0) begin
          state_d = ST_ACCUM;
        end else begin
          bit_d   = bit_q - BW'(1);
          state_d = ST_PRECHARGE;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_sum;
        oor_d = oor_q | sample_oor;
        if (samp_q == SW'(N_SAMP - 1)) begin
          // Result registers load here so they are already valid during DONE.
          res_ch_d   = ch_q;
          res_data_d = N_VDAC'(rnd_sum >> AVG_LOG2);
          res_oor_d  = oor_q | sample_oor;
          state_d    = ST_DONE;
        end else begin
          samp_d  = samp_q + SW'(1);
          code_d  = '0;
          bit_d   = BIT_TOP;
          state_d = ST_PRECHARGE;
        end
      end
      ST_DONE: begin
        acc_d   = '0;
        oor_d   = 1'b0;
        samp_d  = '0;
        code_d  = '0;
        bit_d   = BIT_TOP;
        state_d = ST_IDLE;
        if (any_from(mask_q, int'(ch_q) + 1)) begin
          ch_d    = lowest_from(mask_q, int'(ch_q) + 1);
          state_d = ST_PRECHARGE;
        end else if (i_cont && |i_ch_mask) begin
          mask_d  = i_ch_mask;
          ch_d    = lowest_from(i_ch_mask, 0);
          state_d = ST_PRECHARGE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_dac_data    = N_VDAC'(VMAX_C);
    o_dac_en      = '0;
    o_precharge_n = '0;
    o_busy        = (state_q != ST_IDLE);
    o_res_valid   = (state_q == ST_DONE);
    if (state_q != ST_IDLE) o_dac_en = N_CH'(1) << ch_q;
    case (state_q)
      ST_TRANSITION: begin
        o_dac_data    = '0;
        o_precharge_n = o_dac_en;
      end
      ST_MEASURE, ST_EVALUATE: begin
        o_dac_data    = trial;
        o_precharge_n = o_dac_en;
      end
      default: ;
    endcase
  end

  assign o_res_ch   = res_ch_q;
  assign o_res_data = res_data_q;
  assign o_res_oor  = res_oor_q;

endmodule

// File: tb/tb_tempsens_sar_ctrl.sv
// Self-checking bench: threshold-model delay cells, randomized thresholds/masks, and a
// reference model that predicts each result as the rounded mean of clamped thresholds.
module tb_tempsens_sar_ctrl;

  localparam int N_VDAC    = 7;
  localparam int N_CH      = 4;
  localparam int AVG_LOG2  = 2;
  localparam int MEAS_CYC  = 4;
  localparam int VMAX      = (1 << N_VDAC) - 1;
  localparam int NS        = 1 << AVG_LOG2;
  localparam int SAMPLE    = N_VDAC * (MEAS_CYC + 3) + 1;
  // One channel occupies its samples plus the DONE cycle.
  localparam int CH_PERIOD = NS * SAMPLE + 1;
  localparam int RND       = (AVG_LOG2 == 0) ? 0 : (1 << (AVG_LOG2 - 1));

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  ch;
    logic [7:0]  data;
    logic        oor;
  } res_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_start = 1'b0;
  logic              i_cont = 1'b0;
  logic [N_CH-1:0]   i_ch_mask = '0;
  logic [N_CH-1:0]   i_tempdelay;
  logic [N_VDAC-1:0] o_dac_data;
  logic [N_CH-1:0]   o_dac_en;
  logic [N_CH-1:0]   o_precharge_n;
  logic              o_busy;
  logic              o_res_valid;
  logic [1:0]        o_res_ch;
  logic [N_VDAC-1:0] o_res_data;
  logic              o_res_oor;

  int   t_val [N_CH];
  int   sched [NS];
  bit   dither_en;
  int   tests, fails;
  res_t got[$];
  res_t exp_q[$];
  int   onehot_bad;
  logic busy_last;
  int   poke_at = -1;
  int   drop_cont_at = -1;

  localparam logic [26:0] RESET_VEC = {7'h7F, 4'b0, 4'b0, 1'b0, 1'b0, 2'b0, 7'b0, 1'b0};

  tempsens_sar_ctrl #(
    .N_VDAC(N_VDAC), .N_CH(N_CH), .AVG_LOG2(AVG_LOG2), .MEAS_CYC(MEAS_CYC)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_cont(i_cont),
    .i_ch_mask(i_ch_mask), .i_tempdelay(i_tempdelay),
    .o_dac_data(o_dac_data), .o_dac_en(o_dac_en), .o_precharge_n(o_precharge_n),
    .o_busy(o_busy), .o_res_valid(o_res_valid), .o_res_ch(o_res_ch),
    .o_res_data(o_res_data), .o_res_oor(o_res_oor)
  );

  always #5 clk = ~clk;

  // Delay cell: output high while the DAC code is at or below the channel threshold.
  always_comb begin
    for (int ch = 0; ch < N_CH; ch++)
      i_tempdelay[ch] = o_dac_en[ch] && (int'(o_dac_data) <= t_val[ch]);
  end

  function automatic logic [26:0] out_vec();
    return {o_dac_data, o_dac_en, o_precharge_n, o_busy, o_res_valid, o_res_ch, o_res_data, o_res_oor};
  endfunction

  function automatic int clamp(input int t);
    return (t < 0) ? 0 : ((t > VMAX) ? VMAX : t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [N_CH-1:0] m);
    i_ch_mask = m;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
  endtask

  // Reference model: ascending channels, each result = rounded mean of clamped thresholds.
  task automatic build_exp(input logic [N_CH-1:0] m, input int nscans);
    int k, sum, v;
    bit oor;
    exp_q.delete();
    k = 0;
    for (int s = 0; s < nscans; s++)
      for (int ch = 0; ch < N_CH; ch++)
        if (m[ch]) begin
          sum = 0;
          oor = 1'b0;
          for (int smp = 0; smp < NS; smp++) begin
            v = clamp((dither_en && ch == 0) ? sched[smp] : t_val[ch]);
            sum += v;
            if (v == 0 || v == VMAX) oor = 1'b1;
          end
          k++;
          exp_q.push_back('{cyc: 32'(CH_PERIOD * k), ch: 8'(ch), data: 8'((sum + RND) >> AVG_LOG2), oor: oor});
        end
  endtask

  // Observes cycles 1..n after start (cycle 1 = first PRECHARGE) and records results.
  task automatic monitor(input int n);
    got.delete();
    onehot_bad = 0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) tick();
      if (dither_en) begin
        int k;
        k = ((c - 1) % CH_PERIOD) / SAMPLE;
        if (k < NS) t_val[0] = sched[k];
      end
      if (c == drop_cont_at) i_cont = 1'b0;
      if (c == poke_at) begin
        i_start   = 1'b1;
        i_ch_mask = '1;
      end else if (c == poke_at + 1) begin
        i_start = 1'b0;
      end
      if (o_busy && !$onehot(o_dac_en)) onehot_bad++;
      if (o_res_valid)
        got.push_back('{cyc: 32'(c), ch: 8'(o_res_ch), data: 8'(o_res_data), oor: o_res_oor});
      busy_last = o_busy;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++;
      $display("FAIL reset_held: outputs %h want %h", out_vec(), RESET_VEC);
    end
    reset = 1'b0;
    repeat (2) tick();
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++;
      $display("FAIL idle_after_reset: outputs %h want %h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_single();
    dither_en = 1'b0;
    t_val = '{45, 0, 0, 0};
    start(4'b0001);
    monitor(CH_PERIOD + 3);
    build_exp(4'b0001, 1);
    tests++;
    if (got.size() != exp_q.size()) begin
      fails++;
      $display("FAIL single_count: got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL single_res%0d: got cyc=%0d ch=%0d data=%0d oor=%0d want cyc=%0d ch=%0d data=%0d oor=%0d",
                 i, got[i].cyc, got[i].ch, got[i].data, got[i].oor, exp_q[i].cyc, exp_q[i].ch, exp_q[i].data, exp_q[i].oor);
      end
    end
    tests++;
    if (busy_last !== 1'b0 || onehot_bad != 0) begin
      fails++;
      $display("FAIL single_busy: busy_end=%0b onehot_errs=%0d want 0/0", busy_last, onehot_bad);
    end
    repeat (5) tick();
    tests++;
    if (o_res_data !== exp_q[0].data[N_VDAC-1:0] || o_res_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_hold: data=%0d valid=%0b want %0d/0", o_res_data, o_res_valid, exp_q[0].data);
    end
  endtask

  task automatic test_two_ch();
    dither_en = 1'b0;
    t_val = '{0, 10, 0, 100};
    start(4'b1010);
    monitor(2 * CH_PERIOD + 3);
    build_exp(4'b1010, 1);
    tests++;
    if (got.size() != exp_q.size()) begin
      fails++;
      $display("FAIL two_ch_count: got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL two_ch_res%0d: got cyc=%0d ch=%0d data=%0d oor=%0d want cyc=%0d ch=%0d data=%0d oor=%0d",
                 i, got[i].cyc, got[i].ch, got[i].data, got[i].oor, exp_q[i].cyc, exp_q[i].ch, exp_q[i].data, exp_q[i].oor);
      end
    end
    tests++;
    if (busy_last !== 1'b0 || onehot_bad != 0) begin
      fails++;
      $display("FAIL two_ch_busy: busy_end=%0b onehot_errs=%0d want 0/0", busy_last, onehot_bad);
    end
  endtask

  task automatic test_dither();
    for (int v = 0; v < 2; v++) begin
      dither_en = 1'b1;
      sched = (v == 0) ? '{40, 41, 41, 41} : '{40, 40, 40, 40};
      start(4'b0001);
      monitor(CH_PERIOD + 3);
      build_exp(4'b0001, 1);
      dither_en = 1'b0;
      tests++;
      if (got.size() != 1 || got[0] !== exp_q[0]) begin
        fails++;
        $display("FAIL dither%0d: got n=%0d data=%0d want n=1 data=%0d",
                 v, got.size(), (got.size() > 0) ? int'(got[0].data) : -1, exp_q[0].data);
      end
    end
  endtask

  task automatic test_oor();
    int thr[2];
    thr = '{200, -5};
    dither_en = 1'b0;
    for (int v = 0; v < 2; v++) begin
      t_val = '{thr[v], 0, 0, 0};
      start(4'b0001);
      monitor(CH_PERIOD + 3);
      build_exp(4'b0001, 1);
      tests++;
      if (got.size() != 1 || got[0] !== exp_q[0]) begin
        fails++;
        $display("FAIL oor_t%0d: got n=%0d data=%0d oor=%0d want data=%0d oor=%0d", thr[v], got.size(),
                 (got.size() > 0) ? int'(got[0].data) : -1, (got.size() > 0) ? int'(got[0].oor) : -1,
                 exp_q[0].data, exp_q[0].oor);
      end
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] m;
    dither_en = 1'b0;
    for (int it = 0; it < 4; it++) begin
      m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int ch = 0; ch < N_CH; ch++) t_val[ch] = int'($urandom_range(0, 170)) - 20;
      start(m);
      monitor($countones(m) * CH_PERIOD + 3);
      build_exp(m, 1);
      tests++;
      if (got.size() != exp_q.size() || busy_last !== 1'b0 || onehot_bad != 0) begin
        fails++;
        $display("FAIL rand%0d_shape: mask=%b n=%0d busy_end=%0b onehot_errs=%0d want n=%0d busy 0",
                 it, m, got.size(), busy_last, onehot_bad, exp_q.size());
      end
      foreach (exp_q[i]) if (i < got.size()) begin
        tests++;
        if (got[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL rand%0d_res%0d: got cyc=%0d ch=%0d data=%0d oor=%0d want cyc=%0d ch=%0d data=%0d oor=%0d",
                   it, i, got[i].cyc, got[i].ch, got[i].data, got[i].oor,
                   exp_q[i].cyc, exp_q[i].ch, exp_q[i].data, exp_q[i].oor);
        end
      end
    end
  endtask

  task automatic test_back_to_back_cont();
    dither_en = 1'b0;
    t_val = '{int'($urandom_range(1, 126)), 0, 0, 0};
    i_cont = 1'b1;
    drop_cont_at = 2 * CH_PERIOD + 50;
    start(4'b0001);
    monitor(3 * CH_PERIOD + 3);
    drop_cont_at = -1;
    i_cont = 1'b0;
    build_exp(4'b0001, 3);
    tests++;
    if (got.size() != exp_q.size() || busy_last !== 1'b0) begin
      fails++;
      $display("FAIL cont_shape: n=%0d busy_end=%0b want n=%0d busy 0", got.size(), busy_last, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL cont_res%0d: got cyc=%0d data=%0d want cyc=%0d data=%0d",
                 i, got[i].cyc, got[i].data, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_start_while_busy();
    dither_en = 1'b0;
    t_val = '{int'($urandom_range(1, 126)), 90, 90, 90};
    poke_at = 60;
    start(4'b0001);
    monitor(CH_PERIOD + 3);
    poke_at = -1;
    build_exp(4'b0001, 1);
    tests++;
    if (got.size() != 1 || got[0] !== exp_q[0] || busy_last !== 1'b0) begin
      fails++;
      $display("FAIL start_while_busy: n=%0d busy_end=%0b want n=1 busy 0", got.size(), busy_last);
    end
  endtask

  task automatic test_zero_mask();
    int busy_seen;
    busy_seen = 0;
    i_cont = 1'b1;
    start('0);
    for (int c = 0; c < 6; c++) begin
      if (o_busy !== 1'b0) busy_seen++;
      tick();
    end
    i_cont = 1'b0;
    tests++;
    if (busy_seen != 0) begin
      fails++;
      $display("FAIL zero_mask: busy cycles %0d want 0", busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    dither_en = 1'b0;
    t_val = '{60, 0, 0, 0};
    start(4'b0001);
    repeat (119) tick();
    tests++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy: busy=%0b want 1", o_busy);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++;
      $display("FAIL reset_mid_vals: outputs %h want %h", out_vec(), RESET_VEC);
    end
    tick();
    reset = 1'b0;
    monitor(CH_PERIOD + 3);
    tests++;
    if (got.size() != 0 || busy_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: results=%0d busy=%0b want 0/0", got.size(), busy_last);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    dither_en = 1'b0;
    t_val = '{0, 0, 0, 0};
    sched = '{0, 0, 0, 0};
    test_reset();
    test_single();
    test_two_ch();
    test_dither();
    test_oor();
    test_random();
    test_back_to_back_cont();
    test_start_while_busy();
    test_zero_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
